fir_pin_driver: RTL

//  Host-side counterpart of the single-tap pin-level FIR (gbsha_top). Generates that block's pin stream on
//  an 8-bit bus: DUT clock on bit 0, DUT reset on bit 1, signed 6-bit word on bits [7:2].

---
 rtl/fir_pin_driver_pkg.sv | 22 ++
 rtl/fir_pin_driver_if.sv | 30 +++
 rtl/fir_pin_clkgen.sv | 32 +++
 rtl/fir_pin_driver.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fir_pin_driver_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the FIR pin driver: sequencer states, pin bit positions
// and default widths/timing.
package fir_pin_driver_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RESET  = 2'd1,
      LOAD   = 2'd2,
      STREAM = 2'd3
   } state_t;

   localparam int PIN_CLK      = 0;
   localparam int PIN_RST      = 1;
   localparam int PIN_WORD_LSB = 2;

   localparam int DEF_BW_IN         = 6;
   localparam int DEF_BW_OUT        = 8;
   localparam int DEF_HALF          = 2;
   localparam int DEF_RESET_PERIODS = 2;

endpackage

// File: rtl/fir_pin_driver_if.sv
`timescale 1ns/1ps
// Host-side bundle of the FIR pin driver: start/coef control, sample stream in,
// captured result stream out and status.
interface fir_pin_driver_if
   import fir_pin_driver_pkg::*;
#(
   parameter int BW_IN  = DEF_BW_IN,
   parameter int BW_OUT = DEF_BW_OUT
);
   logic                     start;
   logic signed [BW_IN-1:0]  coef;
   logic                     s_valid;
   logic signed [BW_IN-1:0]  s_data;
   logic                     s_ready;
   logic                     m_valid;
   logic [BW_OUT-1:0]        m_data;
   logic                     m_mismatch;
   logic [7:0]               err_count;
   logic                     busy;

   modport master (
      output start, coef, s_valid, s_data,
      input  s_ready, m_valid, m_data, m_mismatch, err_count, busy
   );

   modport slave (
      input  start, coef, s_valid, s_data,
      output s_ready, m_valid, m_data, m_mismatch, err_count, busy
   );
endinterface

// File: rtl/fir_pin_clkgen.sv
`timescale 1ns/1ps
// Free-running phase counter for the pin-level DUT clock: one DUT period is 2*HALF clk cycles,
// with strobes on the first and last cycle of each period.
module fir_pin_clkgen #(
   parameter int HALF = 2
) (
   input  logic clk,
   input  logic reset,
   output logic dut_clk,
   output logic period_start,
   output logic period_end
);
   localparam int P  = 2 * HALF;
   localparam int CW = $clog2(P);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (cnt == CW'(P - 1))
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   // DUT rising edge lands on the cnt HALF-1 -> HALF transition
   assign dut_clk      = (cnt >= CW'(HALF));
   assign period_start = (cnt == '0);
   assign period_end   = (cnt == CW'(P - 1));

endmodule

// File: rtl/fir_pin_driver.sv
`timescale 1ns/1ps
// Drives the single-tap pin-level FIR through reset, coefficient load and a sample stream,
// then captures each returned word and compares it with the truncated local product.
module fir_pin_driver
   import fir_pin_driver_pkg::*;
#(
   parameter int BW_IN         = DEF_BW_IN,
   parameter int BW_OUT        = DEF_BW_OUT,
   parameter int HALF          = DEF_HALF,
   parameter int RESET_PERIODS = DEF_RESET_PERIODS
) (
   input  logic             clk,
   input  logic             reset,
   fir_pin_driver_if.slave  host,
   output logic [7:0]       pin_out,
   input  logic [7:0]       pin_in
);
   localparam int RPW = $clog2(RESET_PERIODS + 1);

   function automatic logic [BW_OUT-1:0] trunc_prod(input logic signed [BW_IN-1:0] a,
                                                    input logic signed [BW_IN-1:0] b);
      logic signed [2*BW_IN-1:0] p;
      p = a * b;
      return p[BW_OUT-1:0];
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t                  state, state_nxt;
   logic [RPW-1:0]          rst_per, rst_per_nxt;
   logic                    dut_clk, period_start, period_end;
   logic                    restart_pend, restart, s_ready, hs;
   logic signed [BW_IN-1:0] coef_q;
   logic signed [BW_IN-1:0] word_p0;
   logic                    dut_rst_q;
   logic [BW_OUT-1:0]       exp_p0;
   logic [BW_OUT-1:0]       m_data_p1;
   logic                    vld_p0, vld_p1, mis_p1;
   logic [7:0]              err_cnt;

   fir_pin_clkgen #(.HALF(HALF)) u_clkgen (
      .clk          (clk),
      .reset        (reset),
      .dut_clk      (dut_clk),
      .period_start (period_start),
      .period_end   (period_end)
   );

   // A start (new or still pending) pre-empts everything until the next period boundary
   assign restart = host.start || restart_pend;
   assign s_ready = (state == STREAM) && period_end && !restart;
   assign hs      = s_ready && host.s_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rst_per <= '0;
      end else begin
         state   <= state_nxt;
         rst_per <= rst_per_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      rst_per_nxt = rst_per;
      if (period_end) begin
         if (restart) begin
            state_nxt   = RESET;
            rst_per_nxt = '0;
         end else begin
            case (state)
               RESET: begin
                  if (rst_per == RPW'(RESET_PERIODS - 1))
                     state_nxt = LOAD;
                  else
                     rst_per_nxt = rst_per + RPW'(1);
               end
               LOAD:    state_nxt = STREAM;
               default: state_nxt = state;
            endcase
         end
      end
   end

   // Stage p0: pin word/reset register, updated only on the edge entering cnt=0
   always_ff @(posedge clk) begin
      if (reset) begin
         restart_pend <= 1'b0;
         dut_rst_q    <= 1'b1;
         word_p0      <= '0;
         vld_p0       <= 1'b0;
      end else begin
         if (period_end)
            restart_pend <= 1'b0;
         else if (host.start)
            restart_pend <= 1'b1;

         if (period_end) begin
            dut_rst_q <= (state_nxt == IDLE) || (state_nxt == RESET);
            case (state_nxt)
               LOAD:    word_p0 <= coef_q;
               STREAM:  if (hs) word_p0 <= host.s_data;
               default: word_p0 <= '0;
            endcase
         end

         if (restart)
            vld_p0 <= 1'b0;
         else if (period_end)
            vld_p0 <= hs;
      end
   end

   always_ff @(posedge clk) begin
      if (host.start)
         coef_q <= host.coef;
      if (hs)
         exp_p0 <= trunc_prod(coef_q, host.s_data);
   end

   // Stage p1: capture at the end of a live period, one-cycle result pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1    <= 1'b0;
         mis_p1    <= 1'b0;
         m_data_p1 <= '0;
         err_cnt   <= '0;
      end else begin
         if (period_end && vld_p0 && !restart) begin
            vld_p1    <= 1'b1;
            mis_p1    <= (pin_in[BW_OUT-1:0] != exp_p0);
            m_data_p1 <= pin_in[BW_OUT-1:0];
         end else if (period_start) begin
            vld_p1 <= 1'b0;
            mis_p1 <= 1'b0;
         end

         if (host.start)
            err_cnt <= '0;
         else if (vld_p1 && mis_p1)
            err_cnt <= sat_inc8(err_cnt);
      end
   end

   always_comb begin
      pin_out                          = '0;
      pin_out[PIN_CLK]                 = dut_clk;
      pin_out[PIN_RST]                 = dut_rst_q;
      pin_out[PIN_WORD_LSB +: BW_IN]   = word_p0;
   end

   assign host.s_ready    = s_ready;
   assign host.m_valid    = vld_p1;
   assign host.m_data     = m_data_p1;
   assign host.m_mismatch = mis_p1;
   assign host.err_count  = err_cnt;
   assign host.busy       = (state != IDLE);

endmodule
